// File: rtl/vote_display_driver.sv
// vote_display_driver: synchronises the voting FSM outputs, converts the vote count to
// BCD (double-dabble) and scans the 8-digit 7-segment display. Option: DISP_BLINK_EN.
module vote_display_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [8:0] vote_count,
  input  logic [1:0] the_winner,
  input  logic [1:0] the_state,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_busy
);

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'b00,
    CONV_SHIFT = 2'b01,
    CONV_LOAD  = 2'b10
  } conv_state_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_CLOSED = 2'b10,
    ST_WIN    = 2'b11
  } vote_state_t;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_I     = 7'h4F;
  localparam logic [6:0] G_D     = 7'h21;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_C     = 7'h46;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_N     = 7'h2B;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_T     = 7'h07;

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Both dividers need at least two counts for the wrap logic to be meaningful.
  if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_bad_divider
    $error("vote_display_driver: REFRESH_DIV and BLINK_DIV must be >= 2");
  end

  function automatic logic [6:0] num_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- synchroniser
  logic [12:0] sync_q1, sync_q2;
  logic [8:0]  vc_s;
  logic [1:0]  win_s;
  vote_state_t state_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {the_state, the_winner, vote_count};
      sync_q2 <= sync_q1;
    end
  end

  assign vc_s    = sync_q2[8:0];
  assign win_s   = sync_q2[10:9];
  assign state_s = vote_state_t'(sync_q2[12:11]);

  // ---------------------------------------------------------------- BCD converter
  conv_state_t conv_state, conv_next;
  logic [3:0]  shift_cnt;
  logic [8:0]  bin_sr, conv_value, last_value;
  logic [11:0] bcd_work, bcd_adj, bcd_reg;
  logic [3:0]  bcd_h, bcd_t, bcd_o;

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    conv_next = conv_state;
    case (conv_state)
      CONV_IDLE:  if (vc_s != last_value) conv_next = CONV_SHIFT;
      CONV_SHIFT: if (shift_cnt == 4'd8) conv_next = CONV_LOAD;
      CONV_LOAD:  conv_next = CONV_IDLE;
      default:    conv_next = CONV_IDLE;
    endcase
  end

  assign bcd_adj = add3(bcd_work);

  // A new value arriving mid-conversion is picked up by the IDLE compare afterwards.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      conv_state <= CONV_IDLE;
      shift_cnt  <= '0;
      bin_sr     <= '0;
      bcd_work   <= '0;
      conv_value <= '0;
      last_value <= '0;
      bcd_reg    <= '0;
    end else begin
      conv_state <= conv_next;
      case (conv_state)
        CONV_IDLE: begin
          if (conv_next == CONV_SHIFT) begin
            bin_sr     <= vc_s;
            conv_value <= vc_s;
            bcd_work   <= '0;
            shift_cnt  <= '0;
          end
        end
        CONV_SHIFT: begin
          {bcd_work, bin_sr} <= {bcd_adj, bin_sr} << 1;
          shift_cnt          <= shift_cnt + 4'd1;
        end
        CONV_LOAD: begin
          bcd_reg    <= bcd_work;
          last_value <= conv_value;
        end
        default: ;
      endcase
    end
  end

  assign bcd_busy = (conv_state != CONV_IDLE);
  assign bcd_h    = bcd_reg[11:8];
  assign bcd_t    = bcd_reg[7:4];
  assign bcd_o    = bcd_reg[3:0];

  // ---------------------------------------------------------------- blink phase
  logic blink_phase;
`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

  // ---------------------------------------------------------------- scan
  logic [RW-1:0] refresh_cnt;
  logic [2:0]    scan_idx;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [6:0] g_h, g_t, g_o, glyph_nxt;

  // Leading zeros blanked; the ones digit is always shown.
  assign g_h = (bcd_h == 4'd0) ? G_BLANK : num_glyph(bcd_h);
  assign g_t = (bcd_h == 4'd0 && bcd_t == 4'd0) ? G_BLANK : num_glyph(bcd_t);
  assign g_o = num_glyph(bcd_o);

  always_comb begin
    glyph_nxt = G_BLANK;
    case (state_s)
      ST_IDLE: begin
        case (scan_idx)
          3'd3:    glyph_nxt = G_I;
          3'd2:    glyph_nxt = G_D;
          3'd1:    glyph_nxt = G_L;
          3'd0:    glyph_nxt = G_E;
          default: ;
        endcase
      end
      ST_OPEN: begin
        case (scan_idx)
          3'd7:    glyph_nxt = G_O;
          3'd6:    glyph_nxt = G_P;
          3'd2:    glyph_nxt = g_h;
          3'd1:    glyph_nxt = g_t;
          3'd0:    glyph_nxt = g_o;
          default: ;
        endcase
      end
      ST_CLOSED: begin
        case (scan_idx)
          3'd5:    glyph_nxt = G_C;
          3'd4:    glyph_nxt = G_L;
          3'd3:    glyph_nxt = G_O;
          3'd2:    glyph_nxt = G_S;
          3'd1:    glyph_nxt = G_E;
          3'd0:    glyph_nxt = G_D;
          default: ;
        endcase
      end
      ST_WIN: begin
        case (scan_idx)
          3'd7:    glyph_nxt = (win_s != 2'b00) ? G_C : G_T;
          3'd6:    glyph_nxt = (win_s != 2'b00) ? G_N : G_I;
          3'd5:    glyph_nxt = (win_s != 2'b00) ? num_glyph({2'b00, win_s}) : G_E;
          3'd2:    glyph_nxt = g_h;
          3'd1:    glyph_nxt = g_t;
          3'd0:    glyph_nxt = g_o;
          default: ;
        endcase
        if (blink_phase && scan_idx >= 3'd5) glyph_nxt = G_BLANK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 8'hFF;
      seg <= G_BLANK;
    end else begin
      an  <= ~(8'd1 << scan_idx);
      seg <= glyph_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_vote_display_driver.sv
// Directed bench for vote_display_driver with REFRESH_DIV=4, BLINK_DIV=8.
// Expected glyphs are hand-derived active-low {g,f,e,d,c,b,a} codes.
module tb_vote_display_driver;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic [8:0] vote_count;
  logic [1:0] the_winner;
  logic [1:0] the_state;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bcd_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  vote_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .vote_count (vote_count),
    .the_winner (the_winner),
    .the_state  (the_state),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .bcd_busy   (bcd_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for digit d to be scanned, then checks its segments.
  task automatic expect_digit(input string tag, input int d, input logic [6:0] exp);
    logic [7:0] want_an;
    logic [6:0] s;
    bit         found;
    want_an = ~(8'd1 << d);
    found   = 1'b0;
    s       = 7'h00;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_100MHz);
      if (an == want_an) begin
        found = 1'b1;
        s     = seg;
      end
    end
    if (!found) check({tag, "_scan_timeout"}, 32'(found), 32'd1);
    else        check(tag, 32'(s), 32'(exp));
  endtask

  task automatic settle();
    repeat (20) @(negedge clk_100MHz);
  endtask

  initial begin
    logic [7:0] exp_an;
    int busy_cnt, done_at, run1, gap, run2, phase;
    bit seen;

    reset_n    = 1'b0;
    vote_count = 9'd0;
    the_winner = 2'b00;
    the_state  = 2'b00;
    repeat (3) @(negedge clk_100MHz);
    check("rst_an",   32'(an),       32'hFF);
    check("rst_seg",  32'(seg),      32'h7F);
    check("rst_dp",   32'(dp),       32'd1);
    check("rst_busy", 32'(bcd_busy), 32'd0);

    // Release on a falling edge; the next rising edge must drive FE.
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check("an_first", 32'(an), 32'hFE);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge clk_100MHz);
      exp_an = ~(8'd1 << (k % 8));
      check("an_rotate", 32'(an), 32'(exp_an));
    end

    // IDLE text
    expect_digit("idle_d3", 3, 7'h4F);
    expect_digit("idle_d0", 0, 7'h06);
    expect_digit("idle_d7", 7, 7'h7F);

    // 123: busy length and latency from input change
    the_state  = 2'b01;
    vote_count = 9'd123;
    busy_cnt = 0; done_at = 0; seen = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk_100MHz);
      if (bcd_busy) begin
        busy_cnt++;
        seen = 1'b1;
      end else if (seen && done_at == 0) begin
        done_at = s;
      end
    end
    check("busy_len_123", 32'(busy_cnt), 32'd10);
    check("latency_123",  32'(done_at),  32'd13);
    expect_digit("v123_d0", 0, 7'h30);
    expect_digit("v123_d1", 1, 7'h24);
    expect_digit("v123_d2", 2, 7'h79);
    expect_digit("open_d7", 7, 7'h40);
    expect_digit("open_d6", 6, 7'h0C);

    // Leading-zero blanking
    vote_count = 9'd7;
    settle();
    expect_digit("v7_d2", 2, 7'h7F);
    expect_digit("v7_d1", 1, 7'h7F);
    expect_digit("v7_d0", 0, 7'h78);
    vote_count = 9'd0;
    settle();
    expect_digit("v0_d0", 0, 7'h40);
    expect_digit("v0_d1", 1, 7'h7F);

    // 5 -> 200 during the fourth SHIFT cycle: no abort, then a retrigger
    vote_count = 9'd5;
    run1 = 0; gap = 0; run2 = 0; phase = 0;
    for (int s = 1; s <= 40; s++) begin
      @(negedge clk_100MHz);
      if (s == 6) vote_count = 9'd200;
      case (phase)
        0: if (bcd_busy) begin phase = 1; run1 = 1; end
        1: if (bcd_busy) run1++; else begin phase = 2; gap = 1; end
        2: if (!bcd_busy) gap++; else begin phase = 3; run2 = 1; end
        3: if (bcd_busy) run2++; else phase = 4;
        default: ;
      endcase
    end
    check("retrig_run1", 32'(run1), 32'd10);
    check("retrig_gap",  32'(gap),  32'd1);
    check("retrig_run2", 32'(run2), 32'd10);
    expect_digit("v200_d2", 2, 7'h24);
    expect_digit("v200_d1", 1, 7'h40);
    expect_digit("v200_d0", 0, 7'h40);

    // CLOSED text
    the_state = 2'b10;
    settle();
    expect_digit("closed_d5", 5, 7'h46);
    expect_digit("closed_d0", 0, 7'h21);
    expect_digit("closed_d7", 7, 7'h7F);

    // Winner display
    the_state  = 2'b11;
    the_winner = 2'b10;
    vote_count = 9'd9;
    settle();
    expect_digit("win_d0", 0, 7'h10);
    expect_digit("win_d1", 1, 7'h7F);
    expect_digit("win_d4", 4, 7'h7F);
`ifndef DISP_BLINK_EN
    expect_digit("win_d7", 7, 7'h46);
    expect_digit("win_d6", 6, 7'h2B);
    expect_digit("win_d5", 5, 7'h24);
`endif
    the_winner = 2'b00;
    settle();
    expect_digit("tie_d0", 0, 7'h10);
`ifndef DISP_BLINK_EN
    expect_digit("tie_d7", 7, 7'h07);
    expect_digit("tie_d6", 6, 7'h4F);
    expect_digit("tie_d5", 5, 7'h06);
`else
    begin
      int vis = 0, blank = 0, bad = 0, bad0 = 0;
      logic [6:0] want;
      for (int i = 0; i < 96; i++) begin
        @(negedge clk_100MHz);
        want = 7'h00;
        case (an)
          8'h7F: want = 7'h07;
          8'hBF: want = 7'h4F;
          8'hDF: want = 7'h06;
          default: ;
        endcase
        if (want != 7'h00) begin
          if (seg == want)        vis++;
          else if (seg == 7'h7F)  blank++;
          else                    bad++;
        end
        if (an == 8'hFE && seg != 7'h10) bad0++;
      end
      check("blink_visible", 32'(vis > 0),   32'd1);
      check("blink_blank",   32'(blank > 0), 32'd1);
      check("blink_bad",     32'(bad),       32'd0);
      check("blink_d0",      32'(bad0),      32'd0);
    end
`endif

    // Reset in the middle of SHIFT
    the_state  = 2'b01;
    vote_count = 9'd300;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_100MHz);
      if (bcd_busy) seen = 1'b1;
    end
    check("busy_rise_300", 32'(seen), 32'd1);
    repeat (2) @(negedge clk_100MHz);
    #2;
    reset_n    = 1'b0;
    vote_count = 9'd0;
    #1;
    check("midrst_an",   32'(an),       32'hFF);
    check("midrst_seg",  32'(seg),      32'h7F);
    check("midrst_dp",   32'(dp),       32'd1);
    check("midrst_busy", 32'(bcd_busy), 32'd0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    settle();
    check("post_rst_busy", 32'(bcd_busy), 32'd0);
    expect_digit("post_rst_d0", 0, 7'h40);
    expect_digit("post_rst_d1", 1, 7'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
